// File: rtl/and8_rr_sequencer_if.sv
// and8_rr_sequencer_if: requester/result bus plus the link to the shared PNU_AND8
//   req/req_data   : level requests and their operands (requester i at [i*WIDTH +: WIDTH])
//   req_ack        : one-hot grant pulse
//   and8_in/out    : byte to the shared AND unit and its combinational result
//   busy/res_*     : sequencer status and the registered result of the last operation
interface and8_rr_sequencer_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(WIDTH / 8) + 1;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ack;
  logic [7:0]            and8_in;
  logic                  and8_out;
  logic                  busy;
  logic                  res_valid;
  logic [IW-1:0]         res_id;
  logic                  res_value;
  logic [CW-1:0]         res_chunks;
  modport master (
    output req, req_data, and8_out,
    input  req_ack, and8_in, busy, res_valid, res_id, res_value, res_chunks
  );
  modport slave (
    input  req, req_data, and8_out,
    output req_ack, and8_in, busy, res_valid, res_id, res_value, res_chunks
  );
endinterface

// File: rtl/and8_rr_sequencer.sv
// and8_rr_sequencer: round-robin sharing of one external 8-input AND across NREQ requesters
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of and8_rr_sequencer_if (requests, AND-unit link, results)
module and8_rr_sequencer #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic clk,
  input logic rst,
  and8_rr_sequencer_if.slave bus
);
  localparam int NCHUNK = WIDTH / 8;
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(NCHUNK) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shift, w_data;
  logic [IW-1:0]    r_ptr, r_gid, r_id, w_gnt, w_idx;
  logic [CW-1:0]    r_cnt, r_chunks;
  logic [NREQ-1:0]  r_ack;
  logic             r_acc, r_value, w_found, w_last;
  // first asserted request searching upward from ptr+1, wrapping
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_gnt == IW'(i)) w_data = bus.req_data[i*WIDTH +: WIDTH];
  end
  // and8_out reflects the chunk currently on and8_in
  assign w_last = (r_cnt == CW'(NCHUNK - 1)) || (EARLY_EXIT && !bus.and8_out);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_found ? RUN : IDLE) :
             r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_ptr    <= IW'(NREQ - 1);
      r_gid    <= '0;
      r_id     <= '0;
      r_cnt    <= '0;
      r_chunks <= '0;
      r_ack    <= '0;
      r_acc    <= 1'b0;
      r_value  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack   <= (r_state == IDLE && w_found) ? NREQ'(1) << w_gnt : '0;
      if (r_state == IDLE && w_found) begin
        r_shift <= w_data;
        r_gid   <= w_gnt;
        r_ptr   <= w_gnt;
        r_acc   <= 1'b1;
        r_cnt   <= '0;
      end
      if (r_state == RUN) begin
        r_acc   <= r_acc & bus.and8_out;
        r_shift <= r_shift >> 8;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_id     <= r_gid;
          r_value  <= r_acc & bus.and8_out;
          r_chunks <= r_cnt + 1'b1;
        end
      end
    end
  assign bus.req_ack    = r_ack;
  assign bus.and8_in    = r_state == RUN ? r_shift[7:0] : 8'h00;
  assign bus.busy       = r_state != IDLE;
  assign bus.res_valid  = r_state == DONE;
  assign bus.res_id     = r_id;
  assign bus.res_value  = r_value;
  assign bus.res_chunks = r_chunks;
endmodule
